// File: rtl/answer_display_pkg.sv
// Shared types for the answer display: glyph codes, FSM states and the segment lookup.
// Pure definitions; no clocked logic and no flow control.
package answer_display_pkg;

    localparam int BCD_W = 40;

    typedef enum logic [3:0] {
        G_D0 = 4'd0, G_D1, G_D2, G_D3, G_D4, G_D5, G_D6, G_D7, G_D8, G_D9,
        G_BLANK, G_MINUS, G_E, G_R, G_F, G_L
    } glyph_t;

    localparam glyph_t G_O = G_D0;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_COMMIT} state_t;

    // Segment order {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] glyph_to_seg(input glyph_t g);
        logic [6:0] s;
        case (g)
            G_D0:    s = 7'h40;
            G_D1:    s = 7'h79;
            G_D2:    s = 7'h24;
            G_D3:    s = 7'h30;
            G_D4:    s = 7'h19;
            G_D5:    s = 7'h12;
            G_D6:    s = 7'h02;
            G_D7:    s = 7'h78;
            G_D8:    s = 7'h00;
            G_D9:    s = 7'h10;
            G_MINUS: s = 7'h3F;
            G_E:     s = 7'h06;
            G_R:     s = 7'h2F;
            G_F:     s = 7'h0E;
            G_L:     s = 7'h47;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: start loads |value|, 32 shift cycles follow; done marks the last shift.
// bcd_o holds the final result from the cycle after done until the next start; no backpressure.
module bin2bcd_seq
    import answer_display_pkg::*;
#(
    parameter bit SIGNED_MODE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [31:0]      value_i,
    output logic             done_o,
    output logic [BCD_W-1:0] bcd_o
);

    logic [31:0]      mag_q;
    logic [BCD_W-1:0] bcd_q;
    logic [BCD_W-1:0] adj_d;
    logic [4:0]       cnt_q;
    logic             act_q;

    always_comb begin
        adj_d = bcd_q;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
            act_q <= 1'b0;
        end else if (start_i) begin
            mag_q <= (SIGNED_MODE && value_i[31]) ? (32'd0 - value_i) : value_i;
            bcd_q <= '0;
            cnt_q <= '0;
            act_q <= 1'b1;
        end else if (act_q) begin
            {bcd_q, mag_q} <= {adj_d[BCD_W-2:0], mag_q, 1'b0};
            cnt_q          <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) act_q <= 1'b0;
        end
    end

    assign done_o = act_q && (cnt_q == 5'd31);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/answer_display.sv
// Converts the calculator answer to decimal glyphs and scans an 8-digit common-anode display.
// A new value commits 35 cycles after it changes ("Err" in 3); a change during conversion restarts it.
module answer_display
    import answer_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit SIGNED_MODE = 1'b1,
    parameter bit ERR_CODE_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an,
    output logic        busy,
    output logic        overflow
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [7:0][3:0] DISP_RST = {{7{4'(G_BLANK)}}, 4'(G_D0)};
    localparam logic [7:0][3:0] DISP_ERR = {{5{4'(G_BLANK)}}, 4'(G_E), 4'(G_R), 4'(G_R)};
    localparam logic [7:0][3:0] DISP_OFL = {{5{4'(G_BLANK)}}, 4'(G_O), 4'(G_F), 4'(G_L)};

    state_t           state_q;
    logic [31:0]      cap_q;
    logic             err_q, busy_q, ovf_q;
    logic [7:0][3:0]  disp_q;
    logic [7:0][3:0]  fmt_d;
    logic [CNT_W-1:0] rcnt_q;
    logic [2:0]       idx_q;
    logic [7:0]       an_q;
    logic [6:0]       seg_q;
    logic [BCD_W-1:0] bcd;
    logic             done, start, is_err, neg, oor;
    int               msd;

    assign is_err = ERR_CODE_EN && (cap_q == 32'hFFFF_FFFF);
    assign neg    = SIGNED_MODE && cap_q[31];
    assign start  = (state_q == S_LOAD) && !is_err;

    bin2bcd_seq #(.SIGNED_MODE(SIGNED_MODE)) u_bcd (
        .clk     (clk),
        .rst_n   (reset),
        .start_i (start),
        .value_i (cap_q),
        .done_o  (done),
        .bcd_o   (bcd)
    );

    // Negative values get one digit less so the minus sign still fits.
    assign oor = neg ? (bcd[39:28] != 12'd0) : (bcd[39:32] != 8'd0);

    always_comb begin
        msd = 0;
        for (int i = 1; i < 8; i++) begin
            if (bcd[4*i +: 4] != 4'd0) msd = i;
        end
        for (int i = 0; i < 8; i++) begin
            if (i <= msd)                     fmt_d[i] = bcd[4*i +: 4];
            else if (neg && (i == msd + 1))   fmt_d[i] = 4'(G_MINUS);
            else                              fmt_d[i] = 4'(G_BLANK);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cap_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            disp_q  <= DISP_RST;
        end else begin
            case (state_q)
                S_IDLE: if (value != cap_q) begin
                    cap_q   <= value;
                    busy_q  <= 1'b1;
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    err_q   <= is_err;
                    state_q <= is_err ? S_COMMIT : S_SHIFT;
                end
                S_SHIFT: if (done) state_q <= S_COMMIT;
                default: begin
                    // Latest value wins: a result for a stale capture is dropped.
                    if (value != cap_q) begin
                        cap_q   <= value;
                        state_q <= S_LOAD;
                    end else begin
                        disp_q  <= err_q ? DISP_ERR : (oor ? DISP_OFL : fmt_d);
                        ovf_q   <= !err_q && oor;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rcnt_q <= '0;
            idx_q  <= '0;
            an_q   <= 8'hFF;
            seg_q  <= 7'h7F;
        end else begin
            if (rcnt_q == CNT_W'(REFRESH_DIV - 1)) begin
                rcnt_q <= '0;
                idx_q  <= idx_q + 3'd1;
            end else begin
                rcnt_q <= rcnt_q + CNT_W'(1);
            end
            an_q  <= ~(8'd1 << idx_q);
            seg_q <= glyph_to_seg(glyph_t'(disp_q[idx_q]));
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign dp       = 1'b1;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_answer_display.sv
// Directed plus random checks of two display instances (signed and unsigned) against a decimal model.
module tb_answer_display;

    localparam int DIV = 4;
    localparam logic [6:0] DSEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                         7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] value_s = '0, value_u = '0;
    logic [6:0]  seg_s, seg_u;
    logic [7:0]  an_s, an_u;
    logic        dp_s, dp_u, busy_s, busy_u, ovf_s, ovf_u;

    int checks = 0;
    int failures = 0;
    logic [6:0] got [8];
    logic [6:0] exp_seg [8];
    logic       exp_ofl;

    always #5 clk = ~clk;

    answer_display #(.REFRESH_DIV(DIV), .SIGNED_MODE(1'b1), .ERR_CODE_EN(1'b1)) dut_s (
        .clk(clk), .reset(reset), .value(value_s), .seg(seg_s), .dp(dp_s),
        .an(an_s), .busy(busy_s), .overflow(ovf_s));

    answer_display #(.REFRESH_DIV(DIV), .SIGNED_MODE(1'b0), .ERR_CODE_EN(1'b1)) dut_u (
        .clk(clk), .reset(reset), .value(value_u), .seg(seg_u), .dp(dp_u),
        .an(an_u), .busy(busy_u), .overflow(ovf_u));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain decimal arithmetic on the value.
    task automatic compute_expect(input logic [31:0] v, input bit sm);
        longint mag;
        bit     neg;
        int     n;
        for (int i = 0; i < 8; i++) exp_seg[i] = 7'h7F;
        exp_ofl = 1'b0;
        if (v == 32'hFFFF_FFFF) begin
            exp_seg[2] = 7'h06; exp_seg[1] = 7'h2F; exp_seg[0] = 7'h2F;
            return;
        end
        neg = sm && v[31];
        mag = neg ? (64'h1_0000_0000 - {32'd0, v}) : {32'd0, v};
        if ((!neg && mag > 99_999_999) || (neg && mag > 9_999_999)) begin
            exp_seg[2] = 7'h40; exp_seg[1] = 7'h0E; exp_seg[0] = 7'h47;
            exp_ofl = 1'b1;
            return;
        end
        n = 0;
        do begin
            exp_seg[n] = DSEG[int'(mag % 10)];
            mag = mag / 10;
            n++;
        end while (mag != 0);
        if (neg) exp_seg[n] = 7'h3F;
    endtask

    task automatic read_display(input bit sel);
        logic [7:0] a;
        for (int i = 0; i < 8; i++) got[i] = 7'h55;
        for (int c = 0; c < 8 * DIV + 2; c++) begin
            @(negedge clk);
            a = sel ? an_u : an_s;
            for (int i = 0; i < 8; i++)
                if (a == ~(8'd1 << i)) got[i] = sel ? seg_u : seg_s;
        end
    endtask

    task automatic compare_display(input string tag, input bit sel, input logic [31:0] v);
        compute_expect(v, !sel);
        read_display(sel);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_dig%0d", tag, i), {25'd0, got[i]}, {25'd0, exp_seg[i]});
        chk({tag, "_ovf"}, {31'd0, sel ? ovf_u : ovf_s}, {31'd0, exp_ofl});
    endtask

    task automatic run_busy(input bit sel, output int n);
        n = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (sel ? busy_u : busy_s) n++;
            else break;
        end
    endtask

    task automatic run_value(input string tag, input bit sel, input logic [31:0] v);
        int n;
        if (sel) value_u = v;
        else     value_s = v;
        run_busy(sel, n);
        chk({tag, "_busy"}, n, (v == 32'hFFFF_FFFF) ? 32'd2 : 32'd34);
        compare_display(tag, sel, v);
    endtask

    initial begin
        int          n;
        bit          bad;
        logic [31:0] v, prev;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_seg", {25'd0, seg_s}, 32'h7F);
        chk("rst_an", {24'd0, an_s}, 32'hFF);
        chk("rst_dp", {31'd0, dp_s}, 32'd1);
        chk("rst_busy", {31'd0, busy_s}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_s}, 32'd0);

        // Scan sequence after release with value 0
        reset = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            chk($sformatf("scan_an_%0d", k), {24'd0, an_s}, {24'd0, ~(8'd1 << (((k - 1) / DIV) % 8))});
            chk($sformatf("scan_seg_%0d", k), {25'd0, seg_s},
                ((((k - 1) / DIV) % 8) == 0) ? 32'h40 : 32'h7F);
            chk($sformatf("scan_busy_%0d", k), {31'd0, busy_s}, 32'd0);
        end

        run_value("v1234", 1'b0, 32'd1234);
        run_value("neg10", 1'b0, 32'hFFFF_FFF6);
        run_value("u10", 1'b1, 32'h0000_000A);
        run_value("uneg", 1'b1, 32'hFFFF_FFF6);
        run_value("err", 1'b0, 32'hFFFF_FFFF);
        run_value("ofl", 1'b0, 32'd100_000_000);
        run_value("max", 1'b0, 32'd99_999_999);
        run_value("nofl", 1'b0, 32'd0 - 32'd10_000_000);
        run_value("nmax", 1'b0, 32'd0 - 32'd9_999_999);
        run_value("uerr", 1'b1, 32'hFFFF_FFFF);
        run_value("zero", 1'b0, 32'd0);

        prev = 32'd0;
        for (int r = 0; r < 24; r++) begin
            case ($urandom_range(0, 4))
                0:       v = $urandom_range(0, 999);
                1:       v = $urandom_range(0, 99_999_999);
                2:       v = 32'd0 - $urandom_range(1, 9_999_999);
                3:       v = $urandom();
                default: v = 32'd0 - $urandom_range(9_999_990, 10_000_010);
            endcase
            if (v == prev) v = v ^ 32'd1;
            prev = v;
            run_value($sformatf("rnd%0d", r), r[0], v);
        end

        // A change during conversion: the stale result never appears
        run_value("pre5", 1'b0, 32'd1000);
        value_s = 32'd5;
        n = 0;
        bad = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (an_s == 8'hFE && seg_s == 7'h12) bad = 1'b1;
            if (busy_s) n++;
            else break;
            if (n == 10) value_s = 32'd77;
        end
        chk("restart_busy", n, 32'd68);
        chk("restart_no5", {31'd0, bad}, 32'd0);
        compare_display("v77", 1'b0, 32'd77);

        // Reset in the middle of a conversion
        value_s = 32'd4321;
        for (int c = 0; c < 12; c++) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_seg", {25'd0, seg_s}, 32'h7F);
        chk("mid_rst_an", {24'd0, an_s}, 32'hFF);
        chk("mid_rst_busy", {31'd0, busy_s}, 32'd0);
        chk("mid_rst_ovf", {31'd0, ovf_s}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        n = 0;
        bad = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (an_s == 8'hFE && seg_s != 7'h40) bad = 1'b1;
            if (an_s != 8'hFE && an_s != 8'hFF && seg_s != 7'h7F) bad = 1'b1;
            if (busy_s) n++;
            else break;
        end
        chk("post_rst_busy", n, 32'd34);
        chk("post_rst_zero", {31'd0, bad}, 32'd0);
        compare_display("v4321", 1'b0, 32'd4321);
        chk("dp_end", {31'd0, dp_s & dp_u}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
